// File: rtl/vc_test_reorder_buf.sv
// Test-only reorder buffer: accepts in-order val/rdy messages and releases them permuted (LIFO by default).
// Define VC_TEST_REORDER_BUF_RAND_EN to select the pop entry pseudo-randomly from an 8-bit LFSR.
module vc_test_reorder_buf #(
  parameter int unsigned p_msg_nbits   = 1,
  parameter int unsigned p_depth       = 4,
  parameter int unsigned p_idle_cycles = 4
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_msg_nbits-1:0] out_msg
);

  localparam int unsigned CW = $clog2(p_depth + 1);
  localparam int unsigned IW = $clog2(p_depth);

  logic [p_msg_nbits-1:0] ent_q [p_depth];
  logic [p_msg_nbits-1:0] ent_d [p_depth];
  logic [CW-1:0]          count_q, count_d;
  logic [7:0]             idle_q, idle_d;
  logic [IW-1:0]          sel;
  logic [CW-1:0]          wr_idx;
  logic                   full, enq, deq;

  always_comb begin
    full    = (count_q == CW'(p_depth));
    in_rdy  = !reset && !full;
    out_val = !reset && (full || (count_q != '0 && idle_q >= 8'(p_idle_cycles)));
    enq     = in_val && in_rdy;
    deq     = out_val && out_rdy;
  end

`ifdef VC_TEST_REORDER_BUF_RAND_EN
  logic [7:0] lfsr_q, lfsr_d, sel_wide;

  // LFSR only steps on a dequeue so the selection holds steady under backpressure.
  always_comb begin
    sel_wide = '0;
    if (count_q != '0) sel_wide = lfsr_q % 8'(count_q);
    sel = '0;
    for (int unsigned i = 0; i < p_depth; i++) begin
      if (sel_wide == 8'(i)) sel = IW'(i);
    end
    lfsr_d = lfsr_q;
    if (deq) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'h01;
    else       lfsr_q <= lfsr_d;
  end
`else
  logic [CW-1:0] top_idx;

  always_comb begin
    top_idx = count_q - CW'(1);
    sel     = '0;
    for (int unsigned i = 0; i < p_depth; i++) begin
      if (top_idx == CW'(i)) sel = IW'(i);
    end
  end
`endif

  always_comb begin
    out_msg = '0;
    for (int unsigned i = 0; i < p_depth; i++) begin
      if (sel == IW'(i)) out_msg = ent_q[i];
    end
  end

  always_comb begin
    ent_d = ent_q;
    if (deq) begin
      for (int unsigned i = 0; i < p_depth - 1; i++) begin
        if (IW'(i) >= sel) ent_d[i] = ent_q[i + 1];
      end
    end
    // Write lands after compaction, so a same-cycle pop shifts the slot down by one.
    wr_idx = deq ? (count_q - CW'(1)) : count_q;
    if (enq) begin
      for (int unsigned i = 0; i < p_depth; i++) begin
        if (wr_idx == CW'(i)) ent_d[i] = in_msg;
      end
    end
    count_d = count_q + CW'(enq) - CW'(deq);
    if (in_val)               idle_d = '0;
    else if (idle_q == 8'hff) idle_d = idle_q;
    else                      idle_d = idle_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      idle_q  <= '0;
    end else begin
      count_q <= count_d;
      idle_q  <= idle_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_vc_test_reorder_buf.sv
// Directed bench for vc_test_reorder_buf (depth 4, 13-bit messages, idle threshold 4).
module tb_vc_test_reorder_buf;

  localparam int unsigned NB = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val, in_rdy, out_val, out_rdy;
  logic [NB-1:0] in_msg, out_msg;

  int n_checks = 0;
  int n_errors = 0;

  logic [NB-1:0] src   [6];
  logic [NB-1:0] exp_o [6];
  logic [NB-1:0] got   [6];
  logic [NB-1:0] got1  [6];

  vc_test_reorder_buf #(
    .p_msg_nbits  (NB),
    .p_depth      (4),
    .p_idle_cycles(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in_val (in_val),
    .in_rdy (in_rdy),
    .in_msg (in_msg),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_msg(out_msg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_rdy", 32'(in_rdy), 32'd0);
    check_eq("rst_out_val", 32'(out_val), 32'd0);
    reset = 1'b0;
  endtask

  task automatic push(input logic [NB-1:0] m);
    @(negedge clk);
    in_val = 1'b1;
    in_msg = m;
    check_eq("push_rdy", 32'(in_rdy), 32'd1);
  endtask

  task automatic run_collect(input string tag, input int n);
    int si  = 0;
    int ri  = 0;
    int cyc = 0;
    out_rdy = 1'b1;
    while (ri < n && cyc < 5000) begin
      @(negedge clk);
      in_val = (si < n);
      in_msg = (si < n) ? src[si] : '0;
      if (out_val && out_rdy) begin
        got[ri] = out_msg;
        ri++;
      end
      if (in_val && in_rdy) si++;
      cyc++;
    end
    @(negedge clk);
    in_val  = 1'b0;
    out_rdy = 1'b0;
    check_eq({tag, "_done"}, 32'(ri), 32'(n));
    check_eq({tag, "_count0"}, 32'(dut.count_q), 32'd0);
    check_eq({tag, "_empty"}, 32'(out_val), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    #1;
    check_eq("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    check_eq("post_rst_out_val", 32'(out_val), 32'd0);
    check_eq("post_rst_count", 32'(dut.count_q), 32'd0);

`ifndef VC_TEST_REORDER_BUF_RAND_EN
    // Test 1: basic LIFO stream
    src   = '{13'h0aa, 13'h0bb, 13'h0cc, 13'h0dd, 13'h0ee, 13'h0ff};
    exp_o = '{13'h0dd, 13'h0ee, 13'h0ff, 13'h0cc, 13'h0bb, 13'h0aa};
    run_collect("t1", 6);
    for (int k = 0; k < 6; k++) check_eq($sformatf("t1_out%0d", k), 32'(got[k]), 32'(exp_o[k]));

    // Test 3: partial buffer drains after exactly 4 idle cycles
    do_reset();
    push(13'h0aa);
    push(13'h0bb);
    @(negedge clk);
    in_val = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("t3_idle%0d_val", k), 32'(out_val), (k == 4) ? 32'd1 : 32'd0);
    end
    check_eq("t3_first", 32'(out_msg), 32'h0bb);
    out_rdy = 1'b1;
    @(negedge clk);
    check_eq("t3_second_val", 32'(out_val), 32'd1);
    check_eq("t3_second", 32'(out_msg), 32'h0aa);
    @(negedge clk);
    out_rdy = 1'b0;
    check_eq("t3_empty", 32'(out_val), 32'd0);
    check_eq("t3_count", 32'(dut.count_q), 32'd0);

    // Test 4: full buffer under backpressure
    do_reset();
    push(13'h011);
    push(13'h022);
    push(13'h033);
    push(13'h044);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_msg = 13'h055;
      check_eq("t4_full_rdy", 32'(in_rdy), 32'd0);
      check_eq("t4_full_val", 32'(out_val), 32'd1);
      check_eq("t4_full_msg", 32'(out_msg), 32'h044);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check_eq("t4_pop_rdy", 32'(in_rdy), 32'd1);
    check_eq("t4_pop_count", 32'(dut.count_q), 32'd3);
    check_eq("t4_pop_val", 32'(out_val), 32'd0);
    @(negedge clk);
    in_val = 1'b0;
    check_eq("t4_refill_count", 32'(dut.count_q), 32'd4);
    check_eq("t4_refill_msg", 32'(out_msg), 32'h055);

    // Simultaneous enqueue and dequeue on a partial buffer
    do_reset();
    push(13'h0aa);
    push(13'h0bb);
    @(negedge clk);
    in_val = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t7_val", 32'(out_val), 32'd1);
    check_eq("t7_msg", 32'(out_msg), 32'h0bb);
    check_eq("t7_rdy", 32'(in_rdy), 32'd1);
    in_val  = 1'b1;
    in_msg  = 13'h0cc;
    out_rdy = 1'b1;
    @(negedge clk);
    in_val  = 1'b0;
    out_rdy = 1'b0;
    check_eq("t7_count", 32'(dut.count_q), 32'd2);
    check_eq("t7_val_low", 32'(out_val), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("t7_top", 32'(out_msg), 32'h0cc);
    out_rdy = 1'b1;
    @(negedge clk);
    check_eq("t7_bottom", 32'(out_msg), 32'h0aa);
    @(negedge clk);
    out_rdy = 1'b0;
    check_eq("t7_count0", 32'(dut.count_q), 32'd0);

    // Test 5: reset mid-operation discards contents
    do_reset();
    push(13'h0aa);
    push(13'h0bb);
    push(13'h0cc);
    @(negedge clk);
    in_val = 1'b0;
    check_eq("t5_count3", 32'(dut.count_q), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_count", 32'(dut.count_q), 32'd0);
    check_eq("t5_rst_rdy", 32'(in_rdy), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("t5_rdy", 32'(in_rdy), 32'd1);
    check_eq("t5_val", 32'(out_val), 32'd0);

    // Test 2: wide messages on fresh state
    src   = '{13'h11aa, 13'h02bb, 13'h13cc, 13'h04dd, 13'h15ee, 13'h06ff};
    exp_o = '{13'h04dd, 13'h15ee, 13'h06ff, 13'h13cc, 13'h02bb, 13'h11aa};
    run_collect("t2", 6);
    for (int k = 0; k < 6; k++) check_eq($sformatf("t2_out%0d", k), 32'(got[k]), 32'(exp_o[k]));
`else
    // Test 6: random order is a permutation and reproducible from reset
    src = '{13'h0aa, 13'h0bb, 13'h0cc, 13'h0dd, 13'h0ee, 13'h0ff};
    run_collect("t6a", 6);
    got1 = got;
    do_reset();
    run_collect("t6b", 6);
    for (int k = 0; k < 6; k++) begin
      int hits = 0;
      for (int j = 0; j < 6; j++) if (got[j] == src[k]) hits++;
      check_eq($sformatf("t6_perm%0d", k), 32'(hits), 32'd1);
      check_eq($sformatf("t6_repeat%0d", k), 32'(got[k]), 32'(got1[k]));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
